// File: rtl/i2s_tx_serializer_pkg.sv
// i2s_tx_serializer_pkg: default audio geometry shared by the I2S transmit and receive paths
package i2s_tx_serializer_pkg;
  localparam int SAMPLE_WIDTH_DEF = 24;
  localparam int SLOT_WIDTH_DEF = 32;
  localparam int BCLK_DIV_DEF = 4;
endpackage

// File: rtl/i2s_tx_serializer_if.sv
// i2s_tx_serializer_if: stereo sample valid/ready channel (left_data, right_data, sample_valid from master; sample_ready from slave)
interface i2s_tx_serializer_if #(parameter int SAMPLE_WIDTH = 24);
  logic [SAMPLE_WIDTH-1:0] left_data;
  logic [SAMPLE_WIDTH-1:0] right_data;
  logic sample_valid;
  logic sample_ready;
  modport master(output left_data, right_data, sample_valid, input sample_ready);
  modport slave(input left_data, right_data, sample_valid, output sample_ready);
endinterface

// File: rtl/i2s_tx_serializer_bclk_gen.sv
// i2s_bclk_gen: divides fast_clk into a 50% bclk (ports fast_clk, rst in; bclk, bclk_fall strobe out, high in the cycle bclk is about to drop)
module i2s_bclk_gen
  import i2s_tx_serializer_pkg::*;
#(
  parameter int BCLK_DIV = BCLK_DIV_DEF
) (
  input  logic fast_clk,
  input  logic rst,
  output logic bclk,
  output logic bclk_fall
);
  localparam int DW = BCLK_DIV > 1 ? $clog2(BCLK_DIV) : 1;
  logic [DW-1:0] div_cnt_q, div_cnt_d;
  logic bclk_q, bclk_d, wrap;
  always_comb begin
    wrap = div_cnt_q == DW'(BCLK_DIV - 1);
    div_cnt_d = wrap ? '0 : div_cnt_q + 1'b1;
    bclk_d = bclk_q ^ wrap;
  end
  always_ff @(posedge fast_clk) begin
    if (rst) begin
      div_cnt_q <= '0;
      bclk_q <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      bclk_q <= bclk_d;
    end
  end
  assign bclk = bclk_q;
  assign bclk_fall = wrap & bclk_q;
endmodule

// File: rtl/i2s_tx_serializer.sv
// i2s_tx_serializer: I2S transmitter (ports fast_clk, rst, s = sample slave if; bclk, lrclk, sdata, underrun out); define UNDERRUN_HOLD_EN to re-send the last pair on underrun instead of muting
module i2s_tx_serializer
  import i2s_tx_serializer_pkg::*;
#(
  parameter int SAMPLE_WIDTH = SAMPLE_WIDTH_DEF,
  parameter int SLOT_WIDTH = SLOT_WIDTH_DEF,
  parameter int BCLK_DIV = BCLK_DIV_DEF
) (
  input  logic fast_clk,
  input  logic rst,
  i2s_tx_serializer_if.slave s,
  output logic bclk,
  output logic lrclk,
  output logic sdata,
  output logic underrun
);
  localparam int FRAME = 2 * SLOT_WIDTH;
  localparam int BW = $clog2(FRAME);
  localparam int IW = SAMPLE_WIDTH > 1 ? $clog2(SAMPLE_WIDTH + 1) : 1;
`ifdef UNDERRUN_HOLD_EN
  localparam bit KEEP = 1'b1;
`else
  localparam bit KEEP = 1'b0;
`endif
  logic upd, frame_start, accept, right_nxt;
  logic [BW-1:0] bit_cnt_q, bit_cnt_d, bit_nxt, pos;
  logic [IW-1:0] idx;
  logic [SAMPLE_WIDTH-1:0] word;
  logic lrclk_q, lrclk_d, sdata_q, sdata_d, hold_full_q, hold_full_d;
  logic [SAMPLE_WIDTH-1:0] hold_l_q, hold_l_d, hold_r_q, hold_r_d, tx_l_q, tx_l_d, tx_r_q, tx_r_d;
  i2s_bclk_gen #(.BCLK_DIV(BCLK_DIV)) u_bclk (
    .fast_clk (fast_clk),
    .rst      (rst),
    .bclk     (bclk),
    .bclk_fall(upd)
  );
  always_comb begin
    bit_nxt = bit_cnt_q == BW'(FRAME - 1) ? '0 : bit_cnt_q + 1'b1;
    frame_start = upd && bit_cnt_q == BW'(FRAME - 1);
    accept = s.sample_valid && !hold_full_q;
    underrun = frame_start && !hold_full_q;
    right_nxt = bit_nxt >= BW'(SLOT_WIDTH);
    pos = right_nxt ? bit_nxt - BW'(SLOT_WIDTH) : bit_nxt;
    idx = IW'(SAMPLE_WIDTH - int'(pos));
    word = right_nxt ? tx_r_q : tx_l_q;
    bit_cnt_d = upd ? bit_nxt : bit_cnt_q;
    lrclk_d = upd ? right_nxt : lrclk_q;
    // slot position 0 is the one-bclk MSB delay; pos>=1 reads tx regs already updated at frame start
    sdata_d = upd ? (pos != '0 && int'(pos) <= SAMPLE_WIDTH ? word[idx] : 1'b0) : sdata_q;
    // an accept coinciding with an empty-holding frame start lands in holding, never bypasses
    hold_full_d = frame_start && hold_full_q ? 1'b0 : (accept ? 1'b1 : hold_full_q);
    hold_l_d = accept ? s.left_data : hold_l_q;
    hold_r_d = accept ? s.right_data : hold_r_q;
    tx_l_d = frame_start ? (hold_full_q ? hold_l_q : (KEEP ? tx_l_q : '0)) : tx_l_q;
    tx_r_d = frame_start ? (hold_full_q ? hold_r_q : (KEEP ? tx_r_q : '0)) : tx_r_q;
  end
  always_ff @(posedge fast_clk) begin
    if (rst) begin
      bit_cnt_q <= BW'(FRAME - 1);
      lrclk_q <= 1'b1;
      sdata_q <= 1'b0;
      hold_full_q <= 1'b0;
      hold_l_q <= '0;
      hold_r_q <= '0;
      tx_l_q <= '0;
      tx_r_q <= '0;
    end else begin
      bit_cnt_q <= bit_cnt_d;
      lrclk_q <= lrclk_d;
      sdata_q <= sdata_d;
      hold_full_q <= hold_full_d;
      hold_l_q <= hold_l_d;
      hold_r_q <= hold_r_d;
      tx_l_q <= tx_l_d;
      tx_r_q <= tx_r_d;
    end
  end
  assign lrclk = lrclk_q;
  assign sdata = sdata_q;
  assign s.sample_ready = !hold_full_q;
endmodule

// File: tb/tb_i2s_tx_serializer.sv
// tb_i2s_tx_serializer: randomized and directed bench against a cycle-count based I2S frame model
module tb_i2s_tx_serializer;
  localparam int SW = 24, SLOT = 32, D = 4, FRAME = 2 * SLOT, FCYC = 2 * D * FRAME;
  logic fast_clk = 1'b0, rst = 1'b1;
  logic bclk, lrclk, sdata, underrun;
  i2s_tx_serializer_if #(.SAMPLE_WIDTH(SW)) sif ();
  i2s_tx_serializer #(.SAMPLE_WIDTH(SW), .SLOT_WIDTH(SLOT), .BCLK_DIV(D)) dut (
    .fast_clk(fast_clk),
    .rst     (rst),
    .s       (sif.slave),
    .bclk    (bclk),
    .lrclk   (lrclk),
    .sdata   (sdata),
    .underrun(underrun)
  );
  always #5 fast_clk = ~fast_clk;
  int checks = 0, failures = 0;
  int t = 0;
  bit full = 1'b0;
  logic [SW-1:0] hl = '0, hr = '0, cl = '0, cr = '0;
  function automatic bit fs_at(int tt);
    int e = tt + 1;
    return (e % (2 * D) == 0) && (((e / (2 * D)) - 1) % FRAME == 0);
  endfunction
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h t=%0d", tag, obs, exp, t);
    end
  endtask
  task automatic check_outputs();
    int n = t / (2 * D);
    int b = (n + FRAME - 1) % FRAME;
    int p = b % SLOT;
    bit ch = b >= SLOT;
    logic [SW-1:0] sh = (ch ? cr : cl) >> (SW - p);
    logic es = (n >= 1 && p >= 1 && p <= SW) ? sh[0] : 1'b0;
    chk("bclk", {31'd0, bclk}, (t / D) % 2);
    chk("lrclk", {31'd0, lrclk}, {31'd0, ch});
    chk("sdata", {31'd0, sdata}, {31'd0, es});
    chk("ready", {31'd0, sif.sample_ready}, {31'd0, !full});
    chk("underrun", {31'd0, underrun}, {31'd0, fs_at(t) && !full});
  endtask
  task automatic step();
    bit fs = fs_at(t);
    bit acc = sif.sample_valid && !full;
    logic [SW-1:0] dl = sif.left_data, dr = sif.right_data;
    @(posedge fast_clk);
    #1;
    if (rst) begin
      t = 0; full = 1'b0; hl = '0; hr = '0; cl = '0; cr = '0;
    end else begin
      if (fs) begin
        if (full) begin
          cl = hl; cr = hr; full = 1'b0;
        end else begin
`ifndef UNDERRUN_HOLD_EN
          cl = '0; cr = '0;
`endif
        end
      end
      if (acc) begin
        hl = dl; hr = dr; full = 1'b1;
      end
      t++;
    end
    check_outputs();
  endtask
  task automatic run(int n, output int urs);
    urs = 0;
    for (int i = 0; i < n; i++) begin
      step();
      urs += int'(underrun);
    end
  endtask
  int urs, acc_cnt, nfs, last_fs, dly;
  bit f, a, sel;
  logic [SW-1:0] p0l, p0r, p1l, p1r;
  initial begin
    sif.sample_valid = 1'b0;
    sif.left_data = '0;
    sif.right_data = '0;
    repeat (3) step();
    rst = 1'b0;
    for (int i = 0; i < 2 * FCYC && !fs_at(t); i++) step();
    chk("first_fs_found", {31'd0, fs_at(t)}, 32'd1);
    chk("first_fs_underrun", {31'd0, underrun}, 32'd1);
    sif.sample_valid = 1'b1;
    sif.left_data = 24'hA5A5A5;
    sif.right_data = 24'h5A5A5A;
    step();
    sif.sample_valid = 1'b0;
    chk("ready_after_fs_accept", {31'd0, sif.sample_ready}, 32'd0);
    run(FCYC, urs);
    chk("frame2_no_underrun", urs, 0);
    run(2 * FCYC, urs);
    chk("idle_underrun_per_frame", urs, 2);
    for (int i = 0; i < 4 * FCYC; i++) begin
      sif.sample_valid = $urandom_range(0, 3) == 0;
      sif.left_data = SW'($urandom);
      sif.right_data = SW'($urandom);
      step();
    end
    p0l = SW'($urandom); p0r = SW'($urandom); p1l = ~p0l; p1r = ~p0r;
    sel = 1'b0;
    sif.sample_valid = 1'b1;
    sif.left_data = p0l;
    sif.right_data = p0r;
    acc_cnt = 0; nfs = 0; last_fs = t; dly = 0;
    for (int i = 0; i < 4 * FCYC; i++) begin
      f = fs_at(t);
      a = sif.sample_ready;
      if (f) begin
        if (nfs > 0) begin
          chk("accepts_per_frame", acc_cnt, 1);
          chk("stream_no_underrun", {31'd0, underrun}, 32'd0);
          chk("accept_delay_le1", {31'd0, dly <= 1}, 32'd1);
        end
        nfs++;
        acc_cnt = 0;
        last_fs = t;
      end
      step();
      if (a) begin
        acc_cnt++;
        dly = t - 1 - last_fs;
        sel = !sel;
        sif.left_data = sel ? p1l : p0l;
        sif.right_data = sel ? p1r : p0r;
      end
    end
    chk("stream_frames_seen", {31'd0, nfs >= 3}, 32'd1);
    for (int i = 0; i < 2 * FCYC && ((t / (2 * D) + FRAME - 1) % FRAME) < SLOT + 4; i++) begin
      sif.sample_valid = $urandom_range(0, 1) == 1;
      sif.left_data = SW'($urandom);
      sif.right_data = SW'($urandom);
      step();
    end
    chk("reached_right_slot", {31'd0, lrclk}, 32'd1);
    sif.sample_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_bclk", {31'd0, bclk}, 32'd0);
    chk("rst_lrclk", {31'd0, lrclk}, 32'd1);
    chk("rst_sdata", {31'd0, sdata}, 32'd0);
    chk("rst_ready", {31'd0, sif.sample_ready}, 32'd1);
    chk("rst_underrun", {31'd0, underrun}, 32'd0);
    repeat (2 * D - 1) step();
    chk("rst_lrclk_before_frame", {31'd0, lrclk}, 32'd1);
    step();
    chk("rst_first_frame_lrclk", {31'd0, lrclk}, 32'd0);
    for (int i = 0; i < 2 * FCYC; i++) begin
      sif.sample_valid = $urandom_range(0, 2) == 0;
      sif.left_data = SW'($urandom);
      sif.right_data = SW'($urandom);
      step();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
